// File: rtl/ppu_pipe.sv
// ppu_pipe: pipelined post-processing unit. It turns accumulator vectors from
// the PE array into saturated fixed-point outputs. Each beat goes through a
// per-channel scale and bias, then an optional relu or relu+clip, then a
// round-half-away-from-zero shift by FRAC_W, then symmetric saturation.
// A small FSM (IDLE/RUN/DRAIN) frames a job of cfg_frames frames, each of
// cfg_len channels.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_cfg_*        job start pulse and configuration, latched in IDLE
//   i_prm_we/addr/scale/bias  write port of the per-channel scale/bias buffers
//   i_valid/o_ready/i_data  accumulator input stream
//   o_valid/i_ready/o_data  result stream; o_last marks the last beat of a frame
//   o_sat                   sticky per-lane saturation flags
//   o_busy, o_done          FSM not idle / one-cycle job-end pulse
//   o_dbg_state             current FSM state (IDLE=0, RUN=1, DRAIN=2)
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both high. A producer holds valid and its data stable until that
// edge. o_ready never depends on i_valid. o_valid/o_data/o_last stay stable
// while stalled.
module ppu_pipe #(
  parameter int VL      = 16,
  parameter int ACC_W   = 24,
  parameter int SCALE_W = 16,
  parameter int BIAS_W  = 32,
  parameter int FRAC_W  = 10,
  parameter int OUT_W   = 18,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [ADDR_W:0]           i_cfg_len,
  input  logic [15:0]               i_cfg_frames,
  input  logic [1:0]                i_cfg_act,
  input  logic [OUT_W-2:0]          i_cfg_clip,
  input  logic                      i_prm_we,
  input  logic [ADDR_W-1:0]         i_prm_addr,
  input  logic [SCALE_W*VL-1:0]     i_prm_scale,
  input  logic [BIAS_W*VL-1:0]      i_prm_bias,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [ACC_W*VL-1:0]       i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [OUT_W*VL-1:0]       o_data,
  output logic                      o_last,
  output logic [VL-1:0]             o_sat,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [1:0]                o_dbg_state
);

  localparam int PROD_W = SCALE_W + ACC_W;
  localparam int SUM_W  = ((PROD_W > BIAS_W) ? PROD_W : BIAS_W) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CH_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [SUM_W-1:0]  SUM_ONE = {{(SUM_W-1){1'b0}}, 1'b1};
  localparam logic [SUM_W-1:0]  HALF    = SUM_ONE << (FRAC_W - 1);
  localparam logic [SUM_W-1:0]  MAX_MAG = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  // scale*acc + bias at full precision, with relu applied before rounding.
  function automatic logic [SUM_W-1:0] f_sum(input logic [SCALE_W-1:0] sc,
                                             input logic [ACC_W-1:0]   ac,
                                             input logic [BIAS_W-1:0]  bi,
                                             input logic               relu);
    logic [PROD_W-1:0] sc_x, ac_x, prod;
    logic [SUM_W-1:0]  s;
    sc_x = {{ACC_W{sc[SCALE_W-1]}}, sc};
    ac_x = {{SCALE_W{ac[ACC_W-1]}}, ac};
    // Low PROD_W bits of the product of sign-extended operands are exact.
    prod = sc_x * ac_x;
    s = {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod} + {{(SUM_W-BIAS_W){bi[BIAS_W-1]}}, bi};
    if (relu && s[SUM_W-1]) s = '0;
    return s;
  endfunction

  // Rounds on the magnitude (half away from zero), saturates, clips, restores
  // the sign. Returns {sat_flag, result}.
  function automatic logic [OUT_W:0] f_post(input logic [SUM_W-1:0] s,
                                            input logic             clip_on,
                                            input logic [OUT_W-2:0] clip);
    logic             neg, sat;
    logic [SUM_W-1:0] mag, rnd;
    logic [OUT_W-2:0] val;
    logic [OUT_W-1:0] res;
    neg = s[SUM_W-1];
    mag = neg ? (~s + SUM_ONE) : s;
    rnd = (mag + HALF) >> FRAC_W;
    sat = (rnd > MAX_MAG);
    val = sat ? MAX_MAG[OUT_W-2:0] : rnd[OUT_W-2:0];
    if (clip_on && (val > clip)) val = clip;
    res = neg ? (~{1'b0, val} + {{(OUT_W-1){1'b0}}, 1'b1}) : {1'b0, val};
    return {sat, res};
  endfunction

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       ch_q, ch_d;
  logic [15:0]             frame_q, frame_d;
  logic [ADDR_W:0]         len_q;
  logic [15:0]             frames_q;
  logic [1:0]              act_q;
  logic [OUT_W-2:0]        clip_q;
  logic [VL-1:0]           sat_q;
  logic                    done_q, done_d;
  logic                    s1_valid_q, s2_valid_q, s3_valid_q;
  logic                    s1_last_q, s2_last_q, s3_last_q;
  logic [SCALE_W*VL-1:0]   scale_mem [DEPTH];
  logic [BIAS_W*VL-1:0]    bias_mem [DEPTH];
  logic [SCALE_W*VL-1:0]   s1_scale_q;
  logic [BIAS_W*VL-1:0]    s1_bias_q;
  logic [ACC_W*VL-1:0]     s1_acc_q;
  logic [SUM_W-1:0]        s2_sum_q [VL];
  logic [SUM_W-1:0]        s2_sum_d [VL];
  logic [OUT_W*VL-1:0]     s3_data_q, post_data;
  logic [VL-1:0]           lane_sat;
  logic                    advance, accept, start_acc, beat_last, relu_en, clip_en;

  // The whole pipe moves together; only a stalled output stage blocks it.
  assign advance   = !(s3_valid_q && !i_ready);
  assign o_ready   = (state_q == S_RUN) && advance;
  assign accept    = i_valid && o_ready;
  assign start_acc = (state_q == S_IDLE) && i_start;
  assign beat_last = ({1'b0, ch_q} == (len_q - LEN_ONE));
  assign relu_en   = (act_q == 2'd1) || (act_q == 2'd2);
  assign clip_en   = (act_q == 2'd2);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          ch_d    = '0;
          frame_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (beat_last) begin
            ch_d    = '0;
            frame_d = frame_q + 16'd1;
            if (frame_q == (frames_q - 16'd1)) state_d = S_DRAIN;
          end else begin
            ch_d = ch_q + CH_ONE;
          end
        end
      end
      S_DRAIN: begin
        // Finish on the edge where the final beat leaves the output stage.
        if (!s1_valid_q && !s2_valid_q && (!s3_valid_q || i_ready)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    post_data = '0;
    lane_sat  = '0;
    for (int l = 0; l < VL; l++) begin
      s2_sum_d[l] = f_sum(s1_scale_q[l*SCALE_W +: SCALE_W], s1_acc_q[l*ACC_W +: ACC_W],
                          s1_bias_q[l*BIAS_W +: BIAS_W], relu_en);
      {lane_sat[l], post_data[l*OUT_W +: OUT_W]} = f_post(s2_sum_q[l], clip_en, clip_q);
    end
  end

  // Parameter buffers and wide datapath registers carry no reset. A read of
  // the address being written in the same cycle returns the old entry.
  always_ff @(posedge i_clk) begin
    if (i_prm_we) begin
      scale_mem[i_prm_addr] <= i_prm_scale;
      bias_mem[i_prm_addr]  <= i_prm_bias;
    end
    if (accept) begin
      s1_acc_q   <= i_data;
      s1_scale_q <= scale_mem[ch_q];
      s1_bias_q  <= bias_mem[ch_q];
    end
    if (advance && s1_valid_q) s2_sum_q <= s2_sum_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      frame_q    <= '0;
      len_q      <= '0;
      frames_q   <= '0;
      act_q      <= '0;
      clip_q     <= '0;
      sat_q      <= '0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_data_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      if (start_acc) begin
        len_q    <= i_cfg_len;
        frames_q <= i_cfg_frames;
        act_q    <= i_cfg_act;
        clip_q   <= i_cfg_clip;
        sat_q    <= '0;
      end else if (advance && s2_valid_q) begin
        sat_q <= sat_q | lane_sat;
      end
      if (advance) begin
        s1_valid_q <= accept;
        s2_valid_q <= s1_valid_q;
        s3_valid_q <= s2_valid_q;
        if (accept)     s1_last_q <= beat_last;
        if (s1_valid_q) s2_last_q <= s1_last_q;
        if (s2_valid_q) begin
          s3_last_q <= s2_last_q;
          s3_data_q <= post_data;
        end
      end
    end
  end

  assign o_valid     = s3_valid_q;
  assign o_data      = s3_data_q;
  assign o_last      = s3_last_q;
  assign o_sat       = sat_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ppu_pipe.sv
// Testbench for ppu_pipe: table of single-beat jobs plus hand-written
// multi-beat sequences (identity frame, backpressure, ignored start, abort).
module tb_ppu_pipe;
  localparam int VL = 16, ACC_W = 24, SCALE_W = 16, BIAS_W = 32;
  localparam int FRAC_W = 10, OUT_W = 18, DEPTH = 64, ADDR_W = 6;
  localparam int OV_W = OUT_W * VL + 1;

  logic                  i_clk, i_rst_n, i_start;
  logic [ADDR_W:0]       i_cfg_len;
  logic [15:0]           i_cfg_frames;
  logic [1:0]            i_cfg_act;
  logic [OUT_W-2:0]      i_cfg_clip;
  logic                  i_prm_we;
  logic [ADDR_W-1:0]     i_prm_addr;
  logic [SCALE_W*VL-1:0] i_prm_scale;
  logic [BIAS_W*VL-1:0]  i_prm_bias;
  logic                  i_valid, o_ready;
  logic [ACC_W*VL-1:0]   i_data;
  logic                  o_valid, i_ready;
  logic [OUT_W*VL-1:0]   o_data;
  logic                  o_last;
  logic [VL-1:0]         o_sat;
  logic                  o_busy, o_done;
  logic [1:0]            o_dbg_state;

  ppu_pipe dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_cfg_len(i_cfg_len), .i_cfg_frames(i_cfg_frames), .i_cfg_act(i_cfg_act),
    .i_cfg_clip(i_cfg_clip), .i_prm_we(i_prm_we), .i_prm_addr(i_prm_addr),
    .i_prm_scale(i_prm_scale), .i_prm_bias(i_prm_bias),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
    .o_sat(o_sat), .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  typedef struct packed {
    logic [1:0]       act;
    logic [16:0]      clip;
    logic [15:0]      scale;
    logic [31:0]      bias;
    logic [3:0][31:0] acc;
    logic [3:0][31:0] exp;
    logic [3:0]       sat;
  } vec_t;

  vec_t             vt [8];
  logic [OV_W-1:0]  exp_q[$];
  logic [OV_W-1:0]  held;
  bit               held_v, mon_en, rdy_rand;
  int               total, bad, cyc, hs_cyc, nbeat;

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every output handshake pops the expected queue; a stalled
  // output must hold its valid and payload until taken.
  always @(negedge i_clk) begin
    if (!mon_en || !i_rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid", o_valid, 1);
        check("stall_hold", {o_last, o_data}, held);
      end
      if (o_valid && i_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check($sformatf("beat%0d", nbeat), {o_last, o_data}, exp_q.pop_front());
        nbeat++;
        hs_cyc = cyc;
        held_v = 1'b0;
      end else if (o_valid) begin
        held_v = 1'b1;
        held   = {o_last, o_data};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [ACC_W*VL-1:0] mk_acc(input logic [3:0][31:0] a);
    logic [ACC_W*VL-1:0] r;
    for (int l = 0; l < VL; l++) r[l*ACC_W +: ACC_W] = a[l%4][ACC_W-1:0];
    return r;
  endfunction

  function automatic logic [OV_W-1:0] mk_out(input logic [3:0][31:0] e, input logic last);
    logic [OV_W-1:0] r;
    r[OV_W-1] = last;
    for (int l = 0; l < VL; l++) r[l*OUT_W +: OUT_W] = e[l%4][OUT_W-1:0];
    return r;
  endfunction

  task automatic set_vec(input int i, input int act, input int clip, input int scale, input int bias,
                         input int a0, input int a1, input int a2, input int a3,
                         input int e0, input int e1, input int e2, input int e3, input int sat);
    vt[i].act   = act[1:0];
    vt[i].clip  = clip[16:0];
    vt[i].scale = scale[15:0];
    vt[i].bias  = bias;
    vt[i].acc   = {a3, a2, a1, a0};
    vt[i].exp   = {e3, e2, e1, e0};
    vt[i].sat   = sat[3:0];
  endtask

  task automatic write_prm(input int addr, input logic [15:0] scale, input logic [31:0] bias);
    i_prm_we    = 1'b1;
    i_prm_addr  = addr[ADDR_W-1:0];
    i_prm_scale = {VL{scale}};
    i_prm_bias  = {VL{bias}};
    @(posedge i_clk); #1;
    i_prm_we = 1'b0;
  endtask

  task automatic start_job(input int len, input int frames, input int act, input int clip);
    i_start      = 1'b1;
    i_cfg_len    = len[ADDR_W:0];
    i_cfg_frames = frames[15:0];
    i_cfg_act    = act[1:0];
    i_cfg_clip   = clip[OUT_W-2:0];
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_beat(input logic [ACC_W*VL-1:0] d);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_data  = d;
    @(negedge i_clk);
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check("input_accept", o_ready, 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_done && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_done_seen"}, o_done, 1);
    check({name, "_done_lat"}, cyc, hs_cyc + 1);
    check({name, "_idle"}, o_busy, 0);
    @(negedge i_clk);
    check({name, "_done_pulse"}, o_done, 0);
    @(posedge i_clk); #1;
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_valid"}, o_valid, 0);
    check({name, "_data"}, o_data, 0);
    check({name, "_last"}, o_last, 0);
    check({name, "_ready"}, o_ready, 0);
    check({name, "_sat"}, o_sat, 0);
    check({name, "_busy"}, o_busy, 0);
    check({name, "_done"}, o_done, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [ACC_W*VL-1:0] d;
    logic [OV_W-1:0]     e;
    int                  v, b;

    i_rst_n = 1'b0; i_start = 1'b0; i_cfg_len = '0; i_cfg_frames = '0; i_cfg_act = '0;
    i_cfg_clip = '0; i_prm_we = 1'b0; i_prm_addr = '0; i_prm_scale = '0; i_prm_bias = '0;
    i_valid = 1'b0; i_data = '0; mon_en = 0; rdy_rand = 0;
    total = 0; bad = 0; cyc = 0; hs_cyc = 0; nbeat = 0;

    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outs("rst");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_reset_outs("post_rst");
    mon_en = 1;

    // act, clip, scale, bias, acc lanes 0..3, expected lanes 0..3, sat lanes 0..3
    set_vec(0, 0, 0,   1024,  0,    1000, -1000, 0, 7,          1000, -1000, 0, 7,     4'b0000);
    set_vec(1, 0, 0,   512,   0,    3, -3, 1, -1,               2, -2, 1, -1,          4'b0000);
    set_vec(2, 0, 0,   1024,  1536, 0, 1, -2, 5,                2, 3, -1, 7,           4'b0000);
    set_vec(3, 0, 0,   32767, 0,    4194303, -4194303, 0, 1,    131071, -131071, 0, 32, 4'b0011);
    set_vec(4, 1, 0,   1024,  0,    -5, 5, 0, -1000,            0, 5, 0, 0,            4'b0000);
    set_vec(5, 2, 100, 1024,  0,    150, 50, -5, 100,           100, 50, 0, 100,       4'b0000);
    set_vec(6, 3, 0,   1024,  0,    -5, 5, -300, 0,             -5, 5, -300, 0,        4'b0000);
    set_vec(7, 2, 100, 32767, 0,    4194303, -4194303, 0, 0,    100, 0, 0, 0,          4'b0001);

    // Single-beat jobs (len 1: the only beat carries o_last). Each start
    // must clear the sat flags left by the previous job.
    for (int i = 0; i < 8; i++) begin
      write_prm(0, vt[i].scale, vt[i].bias);
      start_job(1, 1, vt[i].act, vt[i].clip);
      check($sformatf("vec%0d_busy", i), o_busy, 1);
      exp_q.push_back(mk_out(vt[i].exp, 1'b1));
      send_beat(mk_acc(vt[i].acc));
      wait_done($sformatf("vec%0d", i));
      check($sformatf("vec%0d_sat", i), o_sat, {4{vt[i].sat}});
    end

    // Identity frame of 4 channels: o_last only on the fourth beat.
    for (int c = 0; c < 4; c++) write_prm(c, 16'd1024, 32'd0);
    start_job(4, 1, 0, 0);
    check("ident_state_run", o_dbg_state, 2'd1);
    for (int k = 0; k < 4; k++) begin
      v = 1000 * (k + 1);
      exp_q.push_back(mk_out({v + 3, -v, v, 7 - k}, k == 3));
    end
    for (int k = 0; k < 4; k++) begin
      v = 1000 * (k + 1);
      send_beat(mk_acc({v + 3, -v, v, 7 - k}));
    end
    wait_done("ident");

    // Backpressure: channel c adds bias c*1024 (= +c after the shift).
    for (int c = 0; c < 8; c++) write_prm(c, 16'd1024, c * 1024);
    start_job(8, 3, 0, 0);
    rdy_rand = 1;
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 8; c++) begin
        b = f * 8 + c;
        e = '0;
        for (int l = 0; l < VL; l++) begin
          v = b * 37 - 400 + l * 3;
          d[l*ACC_W +: ACC_W] = v[ACC_W-1:0];
          v = v + c;
          e[l*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
        e[OV_W-1] = (c == 7);
        exp_q.push_back(e);
        send_beat(d);
      end
    end
    wait_done("bp");
    rdy_rand = 0;
    check("bp_all_beats_out", exp_q.size(), 0);

    // A start pulse during RUN must not restart the job or change its mode.
    write_prm(0, 16'd1024, 32'd0);
    write_prm(1, 16'd1024, 32'd0);
    start_job(2, 1, 0, 0);
    exp_q.push_back(mk_out({40, 30, 20, 10}, 1'b0));
    send_beat(mk_acc({40, 30, 20, 10}));
    start_job(3, 1, 1, 0);
    check("ign_busy", o_busy, 1);
    check("ign_state", o_dbg_state, 2'd1);
    exp_q.push_back(mk_out({-40, -30, -20, -10}, 1'b1));
    send_beat(mk_acc({-40, -30, -20, -10}));
    wait_done("ign");

    // Reset in the middle of a frame: beats in flight are dropped.
    start_job(4, 1, 0, 0);
    mon_en = 0;
    send_beat(mk_acc({1, 2, 3, 4}));
    send_beat(mk_acc({5, 6, 7, 8}));
    i_rst_n = 1'b0;
    #1;
    check_reset_outs("abort");
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outs("abort_hold");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_reset_outs("abort_rel");
    exp_q.delete();
    mon_en = 1;

    start_job(2, 1, 0, 0);
    exp_q.push_back(mk_out({-77, 66, 0, 555}, 1'b0));
    exp_q.push_back(mk_out({12, -13, 14, -15}, 1'b1));
    send_beat(mk_acc({-77, 66, 0, 555}));
    send_beat(mk_acc({12, -13, 14, -15}));
    wait_done("after_abort");
    check("after_abort_beats_out", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_pipe.md
# ppu_pipe

Parametrised, fully pipelined post-processing unit that converts accumulator vectors from the PE array into saturated fixed-point outputs. It applies a per-channel scale, a per-channel bias, a selectable activation, round-half-away-from-zero right shift and symmetric saturation. Streams are valid/ready with full backpressure, and the block runs a framed job under a small control FSM. It sits between the accumulator drain and the quantize/softmax stages, and replaces the fixed-width, non-stallable scale/bias/relu path.

## Interface
- VL, 16: lanes per vector
- ACC_W, 24: signed accumulator width per lane
- SCALE_W, 16: signed scale width per lane, Q(FRAC_W)
- BIAS_W, 32: signed bias width per lane, already in product scale
- FRAC_W, 10: fractional bits removed by the output shift
- OUT_W, 18: signed output width per lane
- DEPTH, 64: scale/bias buffer entries (channels)
- ADDR_W, 6: address width, equal to clog2(DEPTH)
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; accepted only in IDLE
- i_cfg_len  in  ADDR_W+1  channels per frame, 1..DEPTH, latched at start
- i_cfg_frames  in  16  frames per job, ≥1, latched at start
- i_cfg_act  in  2  0 none, 1 relu, 2 relu+clip, 3 reserved (acts as 0); latched
- i_cfg_clip  in  OUT_W-1  unsigned clip ceiling for mode 2; latched
- i_prm_we  in  1  scale/bias buffer write enable
- i_prm_addr  in  ADDR_W  write address
- i_prm_scale  in  SCALE_W*VL  scale write data
- i_prm_bias  in  BIAS_W*VL  bias write data
- i_valid / o_ready  in/out  1  input handshake
- i_data  in  ACC_W*VL  accumulator vector, lane 0 in the LSBs
- o_valid / i_ready  out/in  1  output handshake
- o_data  out  OUT_W*VL  result vector
- o_last  out  1  high with the last beat of each frame
- o_sat  out  VL  sticky per-lane saturation flags, cleared on an accepted start
- o_busy  out  1  high when the FSM is not in IDLE
- o_done  out  1  one-cycle pulse at job end

## Operation
- FSM states:
  - IDLE: on i_start, latch config, clear o_sat and counters, go to RUN.
  - RUN: accept beats; after frames*len beats are accepted, go to DRAIN.
  - DRAIN: when the pipeline is empty, pulse o_done and go to IDLE.
- i_start outside IDLE is ignored.
- o_ready = (state == RUN) and advance, where advance = !(s3_valid && !i_ready).
- Channel counter ch (0..len-1): increments per accepted beat and wraps to 0. The frame counter increments on the wrap.
- Beat address = ch. The tag last = (ch == len-1) travels down the pipe.
- Stage 1: registered buffer read at ch; prod = signed scale*acc, width SCALE_W+ACC_W.
- Stage 2: sum = prod + sign-extended bias, width max(SCALE_W+ACC_W, BIAS_W)+1. Activation:
  - relu zeroes negative values.
  - Mode 2 additionally caps the output at clip after stage 3 (result = min(sat, clip)).
- Stage 3 rounding: take |sum|; add 1 if bit FRAC_W-1 is set, after >>FRAC_W; restore the sign.
- Stage 3 saturation: limit to ±(2^(OUT_W-1)-1); on saturation set o_sat[lane].
- Buffer write and read to the same address in the same cycle: the read returns the old data.
- The parameter buffers are writable in any state. Writes during RUN take effect on subsequent reads.

## Timing
- Latency: 3 cycles from input accept to o_valid with no stall. Throughput is 1 beat per cycle.
- All stages hold while advance is low. o_data and o_last are stable while o_valid && !i_ready.
- o_done is asserted the cycle after the final beat's output handshake, and the FSM is back in IDLE in that same cycle.
- Reset: FSM IDLE; counters 0; all pipe valids 0.
  - Outputs: o_valid 0, o_data 0, o_last 0, o_ready 0, o_sat 0, o_busy 0, o_done 0.
  - Buffer contents are undefined.
- Reset mid-job aborts the job immediately. No o_done is produced and in-flight beats are discarded.
- len = 1: every beat has o_last = 1.

## Test plan
Defaults are used in all tests.
- Identity: scale 1024, bias 0, mode 0, len 4, frames 1, acc lanes 1000/-1000/0/7 -> out 1000/-1000/0/7; o_last on beat 4; o_done 1 cycle after the last handshake.
- Rounding: scale 512, acc 3/-3/1/-1 -> 2/-2/1/-1; bias 1536 with acc 0 -> 2.
- Saturation: acc 4194303, scale 32767 -> 131071 and o_sat[lane] set; the negative counterpart gives -131071. o_sat clears on the next start.
- Activation: mode 1, acc -5 -> 0; mode 2 with clip 100: value 150 -> 100, value 50 -> 50, value -5 -> 0.
- Backpressure: random i_ready at 30% duty, len 8, frames 3 -> all 24 beats arrive in order, with o_last on beats 8/16/24 and no drops or duplicates. o_data is held while stalled.
- Control: i_start during RUN is ignored; reset asserted mid-frame -> all outputs take their reset values and a new job runs correctly.
